// File: rtl/golife_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : golife_pkg
//  Description : Shared constants, state encoding and width helpers for the
//                golife cell array and its grid reader.
//  Revision    : 1.0 - initial release
// ============================================================================
package golife_pkg;

    // Default side length of the square cell grid.
    localparam int c_DEFAULT_SIDEWIDTH = 10;

    // Cell encodings shared with the cell array.
    localparam logic c_LIVE = 1'b1;
    localparam logic c_DEAD = 1'b0;

    // Reader control states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Plain-vector views of the states for the FSM register.
    localparam logic [1:0] c_ST_IDLE   = IDLE;
    localparam logic [1:0] c_ST_STREAM = STREAM;
    localparam logic [1:0] c_ST_DONE   = DONE;

    // Row index width; never below one bit so a 1x1 grid still has an index.
    function automatic int idx_width(input int side);
        return (side > 1) ? $clog2(side) : 1;
    endfunction

    // Width holding any population of a full side x side frame.
    function automatic int pop_width(input int side);
        return $clog2(side * side + 1);
    endfunction

    // Width holding the population of one row.
    function automatic int cnt_width(input int side);
        return $clog2(side + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/golife_row_popcount.sv
`default_nettype none
// ============================================================================
//  Module      : golife_row_popcount
//  Description : Combinational count of live cells in one grid row.
//  Ports       : row   - SIDEWIDTH cells, bit j = column j
//                count - number of set bits in row
//  Revision    : 1.0 - initial release
// ============================================================================
module golife_row_popcount
    import golife_pkg::*;
#(
    parameter int SIDEWIDTH = c_DEFAULT_SIDEWIDTH
) (
    input  logic [SIDEWIDTH-1:0]            row,
    output logic [cnt_width(SIDEWIDTH)-1:0] count
);

    localparam int c_CNTW = cnt_width(SIDEWIDTH);

    always_comb begin
        count = '0;
        for (int i = 0; i < SIDEWIDTH; i++) begin
            count = count + c_CNTW'(row[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/golife_grid_reader.sv
`default_nettype none
// ============================================================================
//  Module      : golife_grid_reader
//  Description : Captures a snapshot of the golife grid on request and
//                streams it out one row per valid/ready handshake, while
//                totalling the live-cell population of the frame.
//  Ports       : clk       - rising-edge clock
//                rst       - asynchronous active-low reset
//                grid      - live grid, grid[i][j] = row i, column j
//                snap      - capture request (ignored unless idle)
//                busy      - frame in progress
//                row_valid - row_data/row_idx/row_last valid
//                row_ready - downstream accepts the current row
//                row_data  - captured row, bit j = column j (0 when invalid)
//                row_idx   - index of the current row
//                row_last  - current row is the final row
//                done      - one-cycle pulse after the final row is accepted
//                pop_count - live cells in the last fully streamed frame
//  Revision    : 1.0 - initial release
// ============================================================================
module golife_grid_reader
    import golife_pkg::*;
#(
    parameter int SIDEWIDTH = c_DEFAULT_SIDEWIDTH,
    parameter int IDXW      = idx_width(SIDEWIDTH),
    parameter int POPW      = pop_width(SIDEWIDTH)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [SIDEWIDTH-1:0][SIDEWIDTH-1:0] grid,
    input  logic                                snap,
    output logic                                busy,
    output logic                                row_valid,
    input  logic                                row_ready,
    output logic [SIDEWIDTH-1:0]                row_data,
    output logic [IDXW-1:0]                     row_idx,
    output logic                                row_last,
    output logic                                done,
    output logic [POPW-1:0]                     pop_count
);

    localparam int              c_CNTW     = cnt_width(SIDEWIDTH);
    localparam logic [IDXW-1:0] c_LAST_IDX = IDXW'(SIDEWIDTH - 1);

    logic [1:0]                          r_state;
    logic [SIDEWIDTH-1:0][SIDEWIDTH-1:0] r_snapshot;
    logic [IDXW-1:0]                     r_row_idx;
    logic [POPW-1:0]                     r_acc;
    logic [POPW-1:0]                     r_pop_count;

    logic                                w_streaming;
    logic                                w_handshake;
    logic [SIDEWIDTH-1:0]                w_row_data;
    logic [c_CNTW-1:0]                   w_row_cnt;
    logic [POPW-1:0]                     w_acc_next;

    // Valid/busy come straight from the state register so an asynchronous
    // reset drops them immediately.
    assign w_streaming = (r_state == c_ST_STREAM);
    assign w_handshake = w_streaming & row_ready;
    assign w_row_data  = w_streaming ? r_snapshot[r_row_idx] : '0;

    golife_row_popcount #(
        .SIDEWIDTH (SIDEWIDTH)
    ) u_row_popcount (
        .row   (w_row_data),
        .count (w_row_cnt)
    );

    assign w_acc_next = r_acc + POPW'(w_row_cnt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_ST_IDLE;
            r_snapshot  <= '0;
            r_row_idx   <= '0;
            r_acc       <= '0;
            r_pop_count <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (snap) begin
                        r_snapshot <= grid;
                        r_row_idx  <= '0;
                        r_acc      <= '0;
                        r_state    <= c_ST_STREAM;
                    end
                end
                c_ST_STREAM: begin
                    if (w_handshake) begin
                        r_acc <= w_acc_next;
                        if (r_row_idx == c_LAST_IDX) begin
                            // Publishing here makes the new count visible in
                            // the same cycle as the done pulse.
                            r_pop_count <= w_acc_next;
                            r_state     <= c_ST_DONE;
                        end else begin
                            r_row_idx <= r_row_idx + IDXW'(1);
                        end
                    end
                end
                c_ST_DONE: begin
                    // Requests arriving here are dropped, not queued.
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = w_streaming;
    assign row_valid = w_streaming;
    assign row_data  = w_row_data;
    assign row_idx   = r_row_idx;
    assign row_last  = w_streaming & (r_row_idx == c_LAST_IDX);
    assign done      = (r_state == c_ST_DONE);
    assign pop_count = r_pop_count;

endmodule
`default_nettype wire

// File: tb/tb_golife_grid_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_golife_grid_reader
//  Description : Self-checking bench for golife_grid_reader. A frame-level
//                model (queue of captured rows) predicts every output each
//                cycle; directed scenarios pin literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_golife_grid_reader;

    localparam int SW   = 10;
    localparam int IDXW = 4;
    localparam int POPW = 7;

    logic                  clk;
    logic                  rst;
    logic [SW-1:0][SW-1:0] grid;
    logic                  snap;
    logic                  busy;
    logic                  row_valid;
    logic                  row_ready;
    logic [SW-1:0]         row_data;
    logic [IDXW-1:0]       row_idx;
    logic                  row_last;
    logic                  done;
    logic [POPW-1:0]       pop_count;

    golife_grid_reader #(
        .SIDEWIDTH (SW),
        .IDXW      (IDXW),
        .POPW      (POPW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .grid      (grid),
        .snap      (snap),
        .busy      (busy),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .row_data  (row_data),
        .row_idx   (row_idx),
        .row_last  (row_last),
        .done      (done),
        .pop_count (pop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Frame-level model: pending rows of the captured frame in a queue.
    // Empty queue and no done owed means idle.
    // ------------------------------------------------------------------
    logic [SW-1:0] m_q[$];
    bit            m_done  = 1'b0;
    int            m_pop   = 0;
    int            m_total = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q.delete();
            m_done = 1'b0;
            m_pop  = 0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_q.size() == 0) begin
            if (snap) begin
                m_total = 0;
                for (int i = 0; i < SW; i++) begin
                    m_q.push_back(grid[i]);
                    m_total += $countones(grid[i]);
                end
            end
        end else if (row_ready) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) begin
                m_done = 1'b1;
                m_pop  = m_total;
            end
        end
    end

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        bit            exp_valid;
        logic [SW-1:0] exp_row;
        exp_valid = (m_q.size() != 0);
        exp_row   = exp_valid ? m_q[0] : '0;
        chk("row_valid", row_valid, exp_valid);
        chk("busy", busy, exp_valid);
        chk("row_data", row_data, exp_row);
        chk("row_last", row_last, (exp_valid && m_q.size() == 1));
        chk("done", done, m_done);
        chk("pop_count", pop_count, m_pop);
        if (exp_valid) begin
            chk("row_idx", row_idx, SW - m_q.size());
        end
    end

    // Collector of accepted rows and done pulses for directed checks.
    logic [SW-1:0] got[SW];
    int            n_acc  = 0;
    int            n_done = 0;

    always @(negedge clk) begin
        if (row_valid && row_ready) begin
            got[row_idx] = row_data;
            n_acc++;
        end
        if (done) n_done++;
    end

    task automatic clear_got();
        for (int i = 0; i < SW; i++) got[i] = '0;
        n_acc = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until done is seen; returns the number of steps taken.
    task automatic wait_done(input string name, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!done && n < 40);
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s timeout actual=no_done expected=done", name);
        end
    endtask

    task automatic load_glider();
        grid       = '0;
        grid[0][1] = 1'b1;
        grid[1][2] = 1'b1;
        grid[2][0] = 1'b1;
        grid[2][1] = 1'b1;
        grid[2][2] = 1'b1;
    endtask

    int n;
    int k;
    int d0;

    initial begin
        rst       = 1'b0;
        snap      = 1'b1;
        row_ready = 1'b1;
        grid      = '1;

        // Reset/idle
        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_valid", row_valid, 0);
        snap = 1'b0;
        rst  = 1'b1;
        repeat (3) step();
        chk("idle_busy", busy, 0);
        chk("idle_valid", row_valid, 0);
        chk("idle_pop", pop_count, 0);
        chk("idle_done", done, 0);
        chk("idle_row_data", row_data, 0);

        // Glider, always ready
        load_glider();
        clear_got();
        snap = 1'b1;
        step();
        snap = 1'b0;
        chk("glider_first_valid", row_valid, 1);
        chk("glider_first_idx", row_idx, 0);
        chk("glider_first_data", row_data, 10'b0000000010);
        wait_done("glider", n);
        chk("glider_latency", n, 10);
        chk("glider_pop", pop_count, 5);
        chk("glider_row0", got[0], 10'b0000000010);
        chk("glider_row1", got[1], 10'b0000000100);
        chk("glider_row2", got[2], 10'b0000000111);
        for (int i = 3; i < SW; i++) chk("glider_row_zero", got[i], 0);
        chk("glider_accepts", n_acc, 10);
        step();
        chk("glider_done_pulse", done, 0);

        // Backpressure: ready 1,0,0,1,0,0,...
        clear_got();
        snap = 1'b1;
        step();
        snap = 1'b0;
        k = 0;
        while (!done && k < 60) begin
            row_ready = (k % 3 == 0);
            step();
            k++;
        end
        chk("bp_cycles", k, 28);
        chk("bp_accepts", n_acc, 10);
        chk("bp_pop", pop_count, 5);
        chk("bp_row2", got[2], 10'b0000000111);
        row_ready = 1'b1;
        step();

        // Snapshot isolation
        clear_got();
        grid = '1;
        snap = 1'b1;
        step();
        snap = 1'b0;
        grid = '0;
        repeat (3) step();
        snap = 1'b1;
        step();
        snap = 1'b0;
        wait_done("isolation", n);
        chk("iso_pop", pop_count, 100);
        for (int i = 0; i < SW; i++) chk("iso_row", got[i], 10'h3FF);
        repeat (3) step();
        chk("iso_no_refire_busy", busy, 0);
        chk("iso_no_refire_valid", row_valid, 0);

        // Reset mid-frame after the row-4 handshake
        load_glider();
        snap = 1'b1;
        step();
        snap = 1'b0;
        repeat (5) step();
        chk("mid_idx_before", row_idx, 5);
        rst = 1'b0;
        #1;
        chk("mid_valid", row_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_pop", pop_count, 0);
        chk("mid_done", done, 0);
        d0 = n_done;
        repeat (2) step();
        rst = 1'b1;
        repeat (2) step();
        chk("mid_no_done", n_done - d0, 0);
        snap = 1'b1;
        step();
        snap = 1'b0;
        chk("mid_restart_idx", row_idx, 0);
        chk("mid_restart_data", row_data, 10'b0000000010);
        wait_done("mid_restart", n);
        chk("mid_restart_pop", pop_count, 5);
        step();

        // Back-to-back frames, snap held high, checkerboard
        for (int i = 0; i < SW; i++)
            for (int j = 0; j < SW; j++)
                grid[i][j] = ((i + j) % 2 == 0);
        d0   = n_done;
        snap = 1'b1;
        step();
        wait_done("b2b_first", n);
        chk("b2b_pop0", pop_count, 50);
        for (int f = 1; f < 3; f++) begin
            wait_done("b2b_next", n);
            chk("b2b_gap", n, 12);
            chk("b2b_pop", pop_count, 50);
        end
        snap = 1'b0;
        repeat (3) step();
        chk("b2b_done_count", n_done - d0, 3);

        // Randomised traffic against the model
        d0 = n_done;
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < SW; i++) grid[i] = SW'($urandom());
            snap      = ($urandom_range(0, 7) == 0);
            row_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 399) != 0);
            step();
        end
        rst  = 1'b1;
        snap = 1'b0;
        repeat (3) step();
        chk("random_frames_seen", (n_done - d0) > 0, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
